mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data requester ports and shared memory port bundle
interface mem_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-cycle 32-bit memory
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter bit FAIR   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  logic r_last_d;
  logic r_valid;
  logic r_port_d;
  logic r_store;
  logic r_err;
  logic r_nop;

  logic w_i_oor;
  logic w_d_oor;
  logic w_d_mis;
  logic w_d_err;
  logic w_pick_i;
  logic w_i_gnt;
  logic w_d_gnt;
  logic w_i_rvalid;
  logic w_d_rvalid;
  logic w_unused;

  assign w_i_oor = |bus.i_addr[31:ADDR_W+2];
  assign w_d_oor = |bus.d_addr[31:ADDR_W+2];
  assign w_d_mis = ((bus.d_be == 4'hF) && (bus.d_addr[1:0] != 2'b00)) ||
                   (((bus.d_be == 4'h3) || (bus.d_be == 4'hC)) && bus.d_addr[0]);
  assign w_d_err = w_d_oor | w_d_mis;
  assign w_unused = ^bus.i_addr[1:0];

  // Fetch wins when alone, or on contention when data was granted last (fair mode only).
  assign w_pick_i = bus.i_req & (~bus.d_req | (FAIR & r_last_d));
  assign w_i_gnt  = rst & w_pick_i;
  assign w_d_gnt  = rst & bus.d_req & ~w_pick_i;

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = (w_i_gnt & ~w_i_oor) | (w_d_gnt & ~w_d_err);
  assign bus.mem_we    = w_d_gnt & bus.d_we & ~w_d_err;
  assign bus.mem_be    = (w_d_gnt & bus.d_we) ? bus.d_be : 4'hF;
  assign bus.mem_addr  = w_i_gnt ? bus.i_addr[ADDR_W+1:2] : bus.d_addr[ADDR_W+1:2];
  assign bus.mem_wdata = bus.d_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_d <= 1'b1;
      r_valid  <= 1'b0;
      r_port_d <= 1'b0;
      r_store  <= 1'b0;
      r_err    <= 1'b0;
      r_nop    <= 1'b0;
    end else begin
      r_valid  <= w_i_gnt | w_d_gnt;
      r_port_d <= w_d_gnt;
      r_store  <= w_d_gnt & bus.d_we;
      r_err    <= w_d_gnt & w_d_err;
      r_nop    <= w_i_gnt & w_i_oor;
      if (w_i_gnt | w_d_gnt) begin
        r_last_d <= w_d_gnt;
      end
    end
  end

  // Responses are masked by rst so a response in flight vanishes the moment reset asserts.
  assign w_i_rvalid = rst & r_valid & ~r_port_d;
  assign w_d_rvalid = rst & r_valid & r_port_d;

  assign bus.i_rvalid = w_i_rvalid;
  assign bus.i_rdata  = !w_i_rvalid ? 32'h0 : (r_nop ? 32'h0000_0013 : bus.mem_rdata);
  assign bus.d_rvalid = w_d_rvalid;
  assign bus.d_rdata  = (w_d_rvalid & ~r_store & ~r_err) ? bus.mem_rdata : 32'h0;
  assign bus.d_err    = w_d_rvalid & r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] mem [0:65535];

  mem_arbiter_if #(.ADDR_W(16)) bus0 ();
  mem_arbiter_if #(.ADDR_W(16)) bus1 ();

  mem_arbiter #(.ADDR_W(16), .FAIR(1'b1)) u_fair (.clk(clk), .rst(rst), .bus(bus0.slave));
  mem_arbiter #(.ADDR_W(16), .FAIR(1'b0)) u_prio (.clk(clk), .rst(rst), .bus(bus1.slave));

  assign bus1.mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) begin
      mem[16'h0040] <= 32'h0000_0093;
      mem[16'h0001] <= 32'hCAFE_F00D;
      mem[16'h0002] <= 32'h1234_5678;
    end else if (bus0.mem_en) begin
      if (bus0.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus0.mem_be[b]) mem[bus0.mem_addr][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
        end
      end else begin
        bus0.mem_rdata <= mem[bus0.mem_addr];
      end
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        eig;
    logic        edg;
    logic        een;
    logic        ewe;
    logic [3:0]  ebe;
    logic [15:0] eaddr;
    logic        eirv;
    logic [31:0] eird;
    logic        edrv;
    logic [31:0] edrd;
    logic        ederr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive0(input vec_t v);
    bus0.i_req   = v.ireq;
    bus0.i_addr  = v.iaddr;
    bus0.d_req   = v.dreq;
    bus0.d_we    = v.dwe;
    bus0.d_be    = v.dbe;
    bus0.d_addr  = v.daddr;
    bus0.d_wdata = v.dwdata;
  endtask

  task automatic check_req(input int k, input vec_t v);
    check($sformatf("v%0d.i_gnt", k), {31'h0, bus0.i_gnt}, {31'h0, v.eig});
    check($sformatf("v%0d.d_gnt", k), {31'h0, bus0.d_gnt}, {31'h0, v.edg});
    check($sformatf("v%0d.mem_en", k), {31'h0, bus0.mem_en}, {31'h0, v.een});
    check($sformatf("v%0d.mem_we", k), {31'h0, bus0.mem_we}, {31'h0, v.ewe});
    check($sformatf("v%0d.mem_be", k), {28'h0, bus0.mem_be}, {28'h0, v.ebe});
    check($sformatf("v%0d.mem_addr", k), {16'h0, bus0.mem_addr}, {16'h0, v.eaddr});
  endtask

  task automatic check_rsp(input int k, input vec_t v);
    check($sformatf("v%0d.i_rvalid", k), {31'h0, bus0.i_rvalid}, {31'h0, v.eirv});
    check($sformatf("v%0d.i_rdata", k), bus0.i_rdata, v.eird);
    check($sformatf("v%0d.d_rvalid", k), {31'h0, bus0.d_rvalid}, {31'h0, v.edrv});
    check($sformatf("v%0d.d_rdata", k), bus0.d_rdata, v.edrd);
    check($sformatf("v%0d.d_err", k), {31'h0, bus0.d_err}, {31'h0, v.ederr});
  endtask

  task automatic idle_inputs();
    bus0.i_req = 1'b0; bus0.i_addr = 32'h0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
    bus0.d_be = 4'hF; bus0.d_addr = 32'h0; bus0.d_wdata = 32'h0;
    bus1.i_req = 1'b0; bus1.i_addr = 32'h0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_be = 4'hF; bus1.d_addr = 32'h0; bus1.d_wdata = 32'h0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //            ireq iaddr         dreq dwe dbe   daddr         dwdata          ig   dg   en   we   be    addr      irv  ird            drv  drd            err
    vecs[0]  = '{1'b1, 32'h100,     1'b0, 1'b0, 4'hF, 32'h0,     32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 16'h40, 1'b1, 32'h93,        1'b0, 32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0,       1'b1, 1'b1, 4'h3, 32'h8,     32'hAAAA5555,   1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 16'h2,  1'b0, 32'h0,         1'b1, 32'h0,          1'b0};
    vecs[2]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'hF, 32'h8,     32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 16'h2,  1'b0, 32'h0,         1'b1, 32'h12345555,   1'b0};
    vecs[3]  = '{1'b0, 32'h0,       1'b1, 1'b1, 4'hF, 32'h6,     32'hFFFFFFFF,   1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 16'h1,  1'b0, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[4]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'hF, 32'h4,     32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 16'h1,  1'b0, 32'h0,         1'b1, 32'hCAFEF00D,   1'b0};
    vecs[5]  = '{1'b1, 32'h40000,   1'b0, 1'b0, 4'hF, 32'h0,     32'h0,          1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0,  1'b1, 32'h13,        1'b0, 32'h0,          1'b0};
    vecs[6]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'hF, 32'h40000, 32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 16'h0,  1'b0, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[7]  = '{1'b0, 32'h0,       1'b1, 1'b0, 4'hC, 32'h9,     32'h0,          1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 16'h2,  1'b0, 32'h0,         1'b1, 32'h0,          1'b1};
    vecs[8]  = '{1'b0, 32'h0,       1'b0, 1'b0, 4'hF, 32'h0,     32'h0,          1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0,  1'b0, 32'h0,         1'b0, 32'h0,          1'b0};
    vecs[9]  = '{1'b0, 32'h0,       1'b1, 1'b1, 4'hC, 32'hA,     32'hBEEF0000,   1'b0, 1'b1, 1'b1, 1'b1, 4'hC, 16'h2,  1'b0, 32'h0,         1'b1, 32'h0,          1'b0};
    vecs[10] = '{1'b1, 32'h100,     1'b1, 1'b0, 4'hF, 32'h8,     32'h0,          1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 16'h40, 1'b1, 32'h93,        1'b0, 32'h0,          1'b0};
    vecs[11] = '{1'b1, 32'h100,     1'b1, 1'b0, 4'hF, 32'h8,     32'h0,          1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 16'h2,  1'b0, 32'h0,         1'b1, 32'hBEEF5555,   1'b0};

    // Reset state, with both requesters asserting to prove grants are masked.
    idle_inputs();
    rst = 1'b0;
    bus0.i_req = 1'b1; bus0.d_req = 1'b1;
    bus1.i_req = 1'b1; bus1.d_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.i_gnt", {31'h0, bus0.i_gnt}, 32'h0);
    check("rst.d_gnt", {31'h0, bus0.d_gnt}, 32'h0);
    check("rst.mem_en", {31'h0, bus0.mem_en}, 32'h0);
    check("rst.mem_we", {31'h0, bus0.mem_we}, 32'h0);
    check("rst.i_rvalid", {31'h0, bus0.i_rvalid}, 32'h0);
    check("rst.d_rvalid", {31'h0, bus0.d_rvalid}, 32'h0);
    check("rst.d_err", {31'h0, bus0.d_err}, 32'h0);
    check("rst.prio_d_gnt", {31'h0, bus1.d_gnt}, 32'h0);
    idle_inputs();
    rst = 1'b1;

    // Vector k's response is checked in the cycle vector k+1 is presented.
    for (int k = 0; k < 12; k++) begin
      if (k > 0) check_rsp(k - 1, vecs[k - 1]);
      drive0(vecs[k]);
      #1;
      check_req(k, vecs[k]);
      @(negedge clk);
    end
    check_rsp(11, vecs[11]);
    idle_inputs();

    // Sustained contention from reset: fair alternates I,D,I,D; priority stays on data.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus0.i_req = 1'b1; bus0.i_addr = 32'h100; bus0.d_req = 1'b1; bus0.d_addr = 32'h8;
    bus1.i_req = 1'b1; bus1.i_addr = 32'h100; bus1.d_req = 1'b1; bus1.d_addr = 32'h8;
    for (int c = 0; c < 4; c++) begin
      logic exp_i;
      exp_i = (c % 2 == 0);
      #1;
      check($sformatf("fair%0d.i_gnt", c), {31'h0, bus0.i_gnt}, {31'h0, exp_i});
      check($sformatf("fair%0d.d_gnt", c), {31'h0, bus0.d_gnt}, {31'h0, ~exp_i});
      check($sformatf("prio%0d.i_gnt", c), {31'h0, bus1.i_gnt}, 32'h0);
      check($sformatf("prio%0d.d_gnt", c), {31'h0, bus1.d_gnt}, 32'h1);
      @(negedge clk);
      check($sformatf("fair%0d.i_rvalid", c), {31'h0, bus0.i_rvalid}, {31'h0, exp_i});
      check($sformatf("fair%0d.d_rvalid", c), {31'h0, bus0.d_rvalid}, {31'h0, ~exp_i});
    end
    idle_inputs();
    @(negedge clk);

    // Reset lands the cycle after a load grant: the response must never surface.
    bus0.d_req = 1'b1; bus0.d_addr = 32'h8;
    #1;
    check("midrst.d_gnt", {31'h0, bus0.d_gnt}, 32'h1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #1;
    check("midrst.d_rvalid", {31'h0, bus0.d_rvalid}, 32'h0);
    check("midrst.d_rdata", bus0.d_rdata, 32'h0);
    check("midrst.i_rvalid", {31'h0, bus0.i_rvalid}, 32'h0);
    check("midrst.i_rdata", bus0.i_rdata, 32'h0);
    check("midrst.mem_en", {31'h0, bus0.mem_en}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("postrst%0d.d_rvalid", c), {31'h0, bus0.d_rvalid}, 32'h0);
      check($sformatf("postrst%0d.d_err", c), {31'h0, bus0.d_err}, 32'h0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
